// File: rtl/uart_pattern_rx_if.sv
// Serial line, pattern configuration and receive/match results of uart_pattern_rx.
// The slave side belongs to the receiver; the master side belongs to whoever drives the line.
interface uart_pattern_rx_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) ();
    logic             rx_in;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             clear_count;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;

    modport master (
        output rx_in, pattern, mask, clear_count,
        input  rx_data, rx_valid, frame_err, busy, match, match_count
    );

    modport slave (
        input  rx_in, pattern, mask, clear_count,
        output rx_data, rx_valid, frame_err, busy, match, match_count
    );
endinterface

// File: rtl/uart_pattern_rx.sv
// UART receiver (8N1, glitch/framing rejection) feeding a maskable sliding-window
// pattern matcher whose history persists across good frames.
module uart_pattern_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int PAT_W        = 8,
    parameter int CNT_W        = 16
) (
    input  logic                sys_clk,
    input  logic                reset,
    uart_pattern_rx_if.slave    bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

    state_t           r_state, w_state_nx;
    logic [1:0]       r_sync;
    logic [TW-1:0]    r_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid, r_frame_err, r_match;
    logic [PAT_W-1:0] r_hist, r_vld;
    logic [CNT_W-1:0] r_count;

    logic             w_rx_s;
    logic             w_start_smp, w_bit_smp, w_stop_smp, w_busy;
    logic [PAT_W-1:0] w_hist_nx, w_vld_nx;
    logic             w_hit;

    // Synchroniser idles high so reset looks like an idle line
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], bus.rx_in};
    end
    assign w_rx_s = r_sync[1];

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (!w_rx_s)                       w_state_nx = S_START;
            S_START: if (w_start_smp)                   w_state_nx = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_smp && r_bit_idx == 3'd7) w_state_nx = S_STOP;
            S_STOP:  if (w_stop_smp)                    w_state_nx = w_rx_s ? S_IDLE : S_WAIT;
            S_WAIT:  if (w_rx_s)                        w_state_nx = S_IDLE;
            default:                                    w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_start_smp = 1'b0;
        w_bit_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        w_busy      = (r_state != S_IDLE);
        case (r_state)
            S_START: w_start_smp = (r_timer == T_HALF);
            S_DATA:  w_bit_smp   = (r_timer == T_FULL);
            S_STOP:  w_stop_smp  = (r_timer == T_FULL);
            default: ;
        endcase
    end

    // Timer restarts on every sample so each later sample lands mid-bit
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_WAIT || w_start_smp || w_bit_smp || w_stop_smp)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
            if (r_state != S_DATA) r_bit_idx <= '0;
            else if (w_bit_smp)    r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    assign w_hist_nx = {r_hist[PAT_W-2:0], w_rx_s};
    assign w_vld_nx  = {r_vld[PAT_W-2:0], 1'b1};
    // A compared position with no received history yet can never match
    assign w_hit = (bus.mask != '0)
                && (((w_hist_nx ^ bus.pattern) & bus.mask) == '0)
                && ((bus.mask & ~w_vld_nx) == '0);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_match     <= 1'b0;
            r_hist      <= '0;
            r_vld       <= '0;
            r_count     <= '0;
        end else begin
            r_rx_valid  <= w_stop_smp && w_rx_s;
            r_frame_err <= w_stop_smp && !w_rx_s;
            r_match     <= w_bit_smp && w_hit;
            if (w_bit_smp) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_hist             <= w_hist_nx;
                r_vld              <= w_vld_nx;
            end else if (w_stop_smp && !w_rx_s) begin
                r_hist <= '0;
                r_vld  <= '0;
            end
            if (w_stop_smp && w_rx_s) r_rx_data <= r_shift;
            if (bus.clear_count)
                r_count <= '0;
            else if (w_bit_smp && w_hit && r_count != '1)
                r_count <= r_count + 1'b1;
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.busy        = w_busy;
    assign bus.match       = r_match;
    assign bus.match_count = r_count;
endmodule

// File: doc/uart_pattern_rx.md
# uart_pattern_rx

Parametrised UART receiver with an integrated serial pattern detector. It samples `rx_in` at a configurable baud divisor and rejects start-bit glitches and framing errors. Received data bits feed a programmable, maskable sliding-window comparator that detects overlapping matches and matches spanning frame boundaries. It replaces the fixed UART-plus-matcher path at the top level and also exposes byte output and a saturating match counter.

## Interface
- `CLKS_PER_BIT`, 217: `sys_clk` cycles per UART bit (25 MHz / 115200); must be ≥ 4.
- `PAT_W`, 8: window width in bits; range 2–32.
- `CNT_W`, 16: width of `match_count`.
- `sys_clk` input 1: single clock domain; all logic is rising-edge.
- `reset` input 1: asynchronous assert, active-low (0 = reset). All state goes to its reset value immediately.
- `rx_in` input 1: asynchronous serial line; idles high.
- `pattern` input PAT_W: target bits. Bit 0 is the newest received bit.
- `mask` input PAT_W: 1 = position compared, 0 = don't-care.
- `clear_count` input 1: synchronous clear of `match_count`; wins over an increment in the same cycle.
- `rx_data` output 8: last good byte; reset 0x00.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates; reset 0.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low; reset 0.
- `busy` output 1: high in any state other than IDLE; reset 0.
- `match` output 1: one-cycle registered pulse per detected match; reset 0.
- `match_count` output CNT_W: number of matches, saturating at all-ones; reset 0.

## Operation
- `rx_in` passes through a 2-FF synchroniser (`rx_s`) before use. Synchroniser flops reset to 1.
- FSM states and transitions:
  - IDLE: when `rx_s`==0, go to START and clear the bit-timer.
  - START: at timer = CLKS_PER_BIT/2−1, sample `rx_s`. If 1, treat as a glitch and return to IDLE with no outputs. If 0, go to DATA with bit index 0 and clear the timer.
  - DATA: at timer = CLKS_PER_BIT−1, sample data bit k. Store it in `rx_data` shift position k (LSB first) and shift it into the history. After bit 7, go to STOP.
  - STOP: at timer = CLKS_PER_BIT−1, sample the stop bit.
    - Stop = 1: load `rx_data`, pulse `rx_valid`, go to IDLE.
    - Stop = 0: pulse `frame_err`, clear the history and valid vector, go to WAIT_IDLE. `rx_data` is not updated.
  - WAIT_IDLE: when `rx_s`==1, go to IDLE.
- History and matching:
  - On each data-bit sample: `hist <= {hist[PAT_W-2:0], bit}` and `vld <= {vld[PAT_W-2:0], 1}`.
  - Hit condition, evaluated on the post-shift values: `mask`≠0, and `((hist ^ pattern) & mask)`==0, and `(mask & ~vld)`==0, i.e. no compared position may lack received history.
  - Overlapping matches are all counted. History persists across frames, so a match can span a frame boundary.
  - Start, stop and glitch bits never enter the history.
- `pattern` and `mask` are read live at each shift. Changing them while `busy` gives undefined match results for that frame only.
- Reset asserted mid-frame: the FSM returns to IDLE and history, vld, counters and outputs are cleared. After release, the block waits for a new falling edge. A line already low at release is taken as a start bit.

## Timing
- Start is detected 2–3 cycles after the `rx_in` falling edge (synchroniser).
- Start is verified CLKS_PER_BIT/2 cycles after detection. Data bit k is sampled (k+1)·CLKS_PER_BIT cycles after verification. The stop bit is sampled at 9·CLKS_PER_BIT.
- `match` is high in the cycle after the completing data-bit sample.
- `match_count` updates in the same cycle that `match` is high.
- `rx_valid` and `frame_err` are high in the cycle after the stop sample.
- A glitch shorter than CLKS_PER_BIT/2 − 3 cycles is rejected. The block returns to IDLE one cycle after the START sample.
- A new start bit is accepted in the first cycle IDLE sees `rx_s`==0, which can be the cycle right after `rx_valid`.

## Test plan
1. Single match: reset, pattern=0x06, mask=0x0F, send 0xA6 (stream 0,1,1,0,0,1,0,1) → exactly one `match`, one cycle after data bit 3 is sampled. `match_count`=1, `rx_data`=0xA6, one `rx_valid`.
2. Overlap: reset, same pattern and mask, send 0x6D (stream 1,0,1,1,0,1,1,0) → `match` after data bits 4 and 7. `match_count`=2.
3. Cross-frame and framing error:
   - Reset, same pattern and mask, send 0xC0 then 0x00 → no match in frame 1; one `match` after frame-2 data bit 0; `match_count`=1.
   - Repeat with frame 1's stop bit driven 0 → `frame_err` pulses once, no match, `rx_valid` pulses only for frame 2.
4. Glitch: drive `rx_in` low for 54 cycles, then high; wait 40 µs → `busy` returns to 0 within 112 cycles. No `rx_valid`, no `frame_err`, no `match`.
5. Reset mid-frame:
   - Send the start bit and 2 data bits, pulse `reset` low for 200 ns, then hold the line high for 40 µs → all outputs at their reset values, `busy`=0.
   - A subsequent 0xA6 → `match_count`=1.
6. Counter behaviour:
   - With CNT_W=2, pattern=0x00, mask=0x01, send 0x00 → `match` on all 8 bits; `match_count` saturates at 3.
   - Assert `clear_count` in the same cycle as a `match` → `match_count`=0.
